// File: rtl/shift_pkg.sv
// Shared definitions for the sequential right shifter.
//   - FSM state encoding (IDLE / SHIFT / DONE)
//   - shift-mode encodings carried on the 2-bit mode input
//   - default data and count widths
package shift_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [1:0] MODE_SRL = 2'b00;
  localparam logic [1:0] MODE_SRA = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;  // decodes as SRL

endpackage

// File: rtl/shift_right_1.sv
// Single-position combinational right-shift stage.
// Ports:
//   in   - operand
//   fill - bit shifted into the MSB when enabled
//   en   - 1: out = {fill, in[WIDTH-1:1]}, 0: out = in
//   out  - stage result
// Shares its shape with the left-shift stage so a right barrel shifter can
// be built by chaining these with power-of-two strides.
module shift_right_1 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in,
  input  logic             fill,
  input  logic             en,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] shifted;

  assign shifted = {fill, in[WIDTH-1:1]};
  assign out     = en ? shifted : in;

endmodule

// File: rtl/shift_right_seq.sv
// Iterative right shifter: one bit position per clock for SRL, SRA and ROR.
// Ports:
//   clk   - clock, all state on the rising edge
//   rst   - synchronous active-high reset (aborts any operation)
//   start - request, accepted only in IDLE or DONE
//   in    - operand, captured on acceptance
//   cnt   - shift amount, captured on acceptance
//   mode  - 00 SRL, 01 SRA, 10 ROR, 11 treated as SRL; captured on acceptance
//   busy  - high while shifting
//   done  - one-cycle result-valid pulse
//   out   - result register, stable outside SHIFT
module shift_right_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [CNT_W-1:0] cnt,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_shift;
  logic             fill;
  logic             accept;

  // Bit entering the MSB for one shift step. The reserved mode falls
  // through to zero fill so it behaves as SRL.
  function automatic logic fill_sel(input logic [1:0] m,
                                    input logic signed [WIDTH-1:0] v);
    logic f;
    case (m)
      MODE_SRA: f = v[WIDTH-1];
      MODE_ROR: f = v[0];
      default:  f = 1'b0;
    endcase
    return f;
  endfunction

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign fill   = fill_sel(mode_q, $signed(out_q));

  shift_right_1 #(.WIDTH(WIDTH)) u_stage (
    .in  (out_q),
    .fill(fill),
    .en  (state_q == SHIFT),
    .out (out_shift)
  );

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) state_d = (cnt == '0) ? DONE : SHIFT;
        else        state_d = IDLE;
      end
      // SHIFT is only entered with rem_q >= 1, so the last step is rem_q == 1.
      SHIFT:   state_d = (rem_q == CNT_W'(1)) ? DONE : SHIFT;
      default: state_d = IDLE;
    endcase
  end

  // ---- outputs decoded from state ----
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  // ---- operand / count / mode registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      rem_q  <= '0;
      mode_q <= MODE_SRL;
    end else if (accept) begin
      out_q  <= in;
      rem_q  <= cnt;
      mode_q <= mode;
    end else if (state_q == SHIFT) begin
      out_q  <= out_shift;
      rem_q  <= rem_q - CNT_W'(1);
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_shift_right_seq.sv
module tb_shift_right_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] din;
  logic [3:0]  dcnt;
  logic [1:0]  dmode;
  logic        busy;
  logic        done;
  logic [15:0] dout;

  int nvec = 0;
  int nbad = 0;

  logic [15:0] sb_q[$];

  typedef struct {
    logic [15:0] din;
    logic [3:0]  cnt;
    logic [1:0]  mode;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  shift_right_seq dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .in   (din),
    .cnt  (dcnt),
    .mode (dmode),
    .busy (busy),
    .done (done),
    .out  (dout)
  );

  function automatic logic [15:0] model(input logic [15:0] x,
                                        input logic [3:0] n,
                                        input logic [1:0] m);
    logic [31:0] d;
    logic [15:0] r;
    case (m)
      2'b01:   r = $signed(x) >>> n;
      2'b10: begin
        d = {x, x} >> n;
        r = d[15:0];
      end
      default: r = x >> n;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one operation, then scramble the inputs to prove they were captured.
  task automatic do_op(input string name, input logic [15:0] x,
                       input logic [3:0] n, input logic [1:0] m,
                       input logic [15:0] exp);
    int          busyc;
    bit          got;
    logic [15:0] e;
    @(negedge clk);
    start = 1'b1; din = x; dcnt = n; dmode = m;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    din   = 16'($urandom);
    dcnt  = 4'($urandom);
    dmode = 2'($urandom);
    busyc = 0;
    got   = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (busy && done) check({name, " busy&done"}, 32'd1, 32'd0);
      if (busy) busyc++;
      if (done) begin
        got = 1'b1;
        e = sb_q.pop_front();
        check({name, " out"}, 32'(dout), 32'(e));
        check({name, " busy cycles"}, 32'(busyc), 32'(n));
      end
    end
    if (!got) begin
      check({name, " done timeout"}, 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end else begin
      @(negedge clk);
      check({name, " done pulse width"}, 32'(done), 32'd0);
      check({name, " out held"}, 32'(dout), 32'(e));
    end
  endtask

  initial begin
    int          dones;
    bit          got;
    logic [15:0] rx;
    logic [3:0]  rn;
    logic [1:0]  rm;

    tbl[0] = '{16'h8001, 4'd1,  2'b00, 16'h4000};
    tbl[1] = '{16'h8000, 4'd15, 2'b01, 16'hFFFF};
    tbl[2] = '{16'h7FFF, 4'd15, 2'b01, 16'h0000};
    tbl[3] = '{16'h0001, 4'd4,  2'b10, 16'h1000};
    tbl[4] = '{16'hA5C3, 4'd8,  2'b10, 16'hC3A5};
    tbl[5] = '{16'h1234, 4'd0,  2'b00, 16'h1234};
    tbl[6] = '{16'h0F00, 4'd4,  2'b11, 16'h00F0};
    tbl[7] = '{16'h8001, 4'd15, 2'b10, 16'h0003};
    tbl[8] = '{16'hFFFF, 4'd15, 2'b00, 16'h0001};
    tbl[9] = '{16'h8000, 4'd0,  2'b01, 16'h8000};

    rst = 1'b1; start = 1'b0; din = '0; dcnt = '0; dmode = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out",  32'(dout), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    rst = 1'b0;

    foreach (tbl[i])
      do_op($sformatf("vec%0d", i), tbl[i].din, tbl[i].cnt, tbl[i].mode,
            tbl[i].exp);

    for (int i = 0; i < 8; i++) begin
      rx = 16'($urandom);
      rn = 4'($urandom);
      rm = 2'($urandom);
      do_op($sformatf("rnd%0d", i), rx, rn, rm, model(rx, rn, rm));
    end

    // start during SHIFT is ignored; start held through DONE is taken back-to-back
    @(negedge clk);
    start = 1'b1; din = 16'hFFFF; dcnt = 4'd3; dmode = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; din = 16'h0000; dcnt = 4'd5; dmode = 2'b01;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    check("hs ignored done seen", 32'(got), 32'd1);
    check("hs ignored out", 32'(dout), 32'h1FFF);
    start = 1'b1; din = 16'h0002; dcnt = 4'd1; dmode = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("hs b2b busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("hs b2b done", 32'(done), 32'd1);
    check("hs b2b out",  32'(dout), 32'h0001);

    // reset in the third SHIFT cycle aborts with no done pulse
    @(negedge clk);
    start = 1'b1; din = 16'hFFFF; dcnt = 4'd10; dmode = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort busy before rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort out",  32'(dout), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("abort no activity", 32'(dones), 32'd0);
    check("abort out stable", 32'(dout), 32'd0);
    do_op("after abort", 16'hA5C3, 4'd3, 2'b01, 16'hF4B8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
